// File: rtl/mul_issue_taint.sv
// Queued operand issuer for a variable-latency multiplier path. Every value
// signal carries a 1-bit shadow taint so information flow into response timing can be checked.
module mul_issue_taint #(
   parameter int WIDTH   = 4,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 12
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_req_valid,
   input  logic                 i_req_valid_t,
   input  logic [WIDTH-1:0]     i_req_a,
   input  logic                 i_req_a_t,
   input  logic [WIDTH-1:0]     i_req_b,
   input  logic                 i_req_b_t,
   output logic                 o_req_ready,
   output logic                 o_req_ready_t,
   output logic                 o_mul_in_valid,
   output logic                 o_mul_in_valid_t,
   output logic [WIDTH-1:0]     o_mul_in_a,
   output logic [WIDTH-1:0]     o_mul_in_b,
   output logic                 o_mul_in_a_t,
   output logic                 o_mul_in_b_t,
   input  logic                 i_mul_out_valid,
   input  logic                 i_mul_out_valid_t,
   input  logic [2*WIDTH-1:0]   i_mul_out_result,
   input  logic                 i_mul_out_result_t,
   output logic                 o_rsp_valid,
   output logic                 o_rsp_valid_t,
   output logic [2*WIDTH-1:0]   o_rsp_data,
   output logic                 o_rsp_data_t,
   output logic [3:0]           o_rsp_latency,
   output logic                 o_rsp_latency_t,
   output logic                 o_rsp_timeout,
   output logic                 o_rsp_timeout_t,
   output logic [1:0]           o_dbg_state
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   localparam logic [3:0]    TO_VAL   = 4'(TIMEOUT);
   localparam logic [3:0]    LAT_ONE  = 4'd1;
   localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
   localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
   localparam logic [PW:0]   CNT_ZERO = '0;
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH-1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   // Request storage: operands and their taints travel together.
   logic [WIDTH-1:0] r_mem_a  [DEPTH];
   logic [WIDTH-1:0] r_mem_b  [DEPTH];
   logic             r_mem_at [DEPTH];
   logic             r_mem_bt [DEPTH];

   logic [PW-1:0]      r_wr_ptr;
   logic [PW-1:0]      r_rd_ptr;
   logic [PW:0]        r_count;
   logic [1:0]         r_state;
   logic [3:0]         r_lat_cnt;
   logic               r_iss_at;
   logic               r_iss_bt;
   logic [2*WIDTH-1:0] r_rsp_data;
   logic [3:0]         r_rsp_latency;
   logic               r_rsp_timeout;
   logic               r_rsp_data_t;
   logic               r_cnt_t;
   logic               r_ctrl_t;

   logic          w_ready;
   logic          w_push;
   logic          w_pop;
   logic [PW-1:0] w_wr_nxt;
   logic [PW-1:0] w_rd_nxt;
   logic          w_wait_taint;
   logic          w_capture;

   assign w_ready  = (r_count != CNT_FULL);
   assign w_push   = i_req_valid & w_ready;
   assign w_pop    = (r_state == S_ISSUE);
   assign w_wr_nxt = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_ONE;
   assign w_rd_nxt = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_ONE;

   // Operand taint of the in-flight request reaches control only while its completion is awaited.
   assign w_wait_taint = (r_state == S_WAIT) &
                         (i_mul_out_valid_t | r_iss_at | r_iss_bt);
   assign w_capture    = (r_state == S_WAIT) &
                         (i_mul_out_valid | (r_lat_cnt == TO_VAL));

   // Queue storage and pointers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_a[i]  <= '0;
            r_mem_b[i]  <= '0;
            r_mem_at[i] <= 1'b0;
            r_mem_bt[i] <= 1'b0;
         end
      end else begin
         if (w_push) begin
            r_mem_a[r_wr_ptr]  <= i_req_a;
            r_mem_b[r_wr_ptr]  <= i_req_b;
            r_mem_at[r_wr_ptr] <= i_req_a_t;
            r_mem_bt[r_wr_ptr] <= i_req_b_t;
            r_wr_ptr           <= w_wr_nxt;
         end
         if (w_pop) begin
            r_rd_ptr <= w_rd_nxt;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Issue / wait / respond sequencing and the held response registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_lat_cnt     <= '0;
         r_iss_at      <= 1'b0;
         r_iss_bt      <= 1'b0;
         r_rsp_data    <= '0;
         r_rsp_latency <= '0;
         r_rsp_timeout <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_count != CNT_ZERO) begin
                  r_state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_lat_cnt <= LAT_ONE;
               r_iss_at  <= r_mem_at[r_rd_ptr];
               r_iss_bt  <= r_mem_bt[r_rd_ptr];
               r_state   <= S_WAIT;
            end
            S_WAIT: begin
               // A completion on the last allowed cycle still counts as a real result.
               if (i_mul_out_valid) begin
                  r_rsp_data    <= i_mul_out_result;
                  r_rsp_latency <= r_lat_cnt;
                  r_rsp_timeout <= 1'b0;
                  r_state       <= S_RESP;
               end else if (r_lat_cnt == TO_VAL) begin
                  r_rsp_data    <= '0;
                  r_rsp_latency <= TO_VAL;
                  r_rsp_timeout <= 1'b1;
                  r_state       <= S_RESP;
               end else begin
                  r_lat_cnt <= r_lat_cnt + LAT_ONE;
               end
            end
            default: begin
               r_state <= (r_count != CNT_ZERO) ? S_ISSUE : S_IDLE;
            end
         endcase
      end
   end

   // Sticky shadow taint; once set only reset clears it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt_t      <= 1'b0;
         r_ctrl_t     <= 1'b0;
         r_rsp_data_t <= 1'b0;
      end else begin
         r_cnt_t  <= r_cnt_t | i_req_valid_t | r_ctrl_t;
         r_ctrl_t <= r_ctrl_t | r_cnt_t | w_wait_taint;
         if (w_capture) begin
            r_rsp_data_t <= r_rsp_data_t | i_mul_out_result_t | r_ctrl_t;
         end
      end
   end

   assign o_req_ready      = w_ready;
   assign o_req_ready_t    = r_cnt_t;
   assign o_mul_in_valid   = (r_state == S_ISSUE);
   assign o_mul_in_valid_t = r_ctrl_t;
   assign o_mul_in_a       = r_mem_a[r_rd_ptr];
   assign o_mul_in_b       = r_mem_b[r_rd_ptr];
   assign o_mul_in_a_t     = r_mem_at[r_rd_ptr];
   assign o_mul_in_b_t     = r_mem_bt[r_rd_ptr];
   assign o_rsp_valid      = (r_state == S_RESP);
   assign o_rsp_valid_t    = r_ctrl_t;
   assign o_rsp_data       = r_rsp_data;
   assign o_rsp_data_t     = r_rsp_data_t;
   assign o_rsp_latency    = r_rsp_latency;
   assign o_rsp_latency_t  = r_ctrl_t;
   assign o_rsp_timeout    = r_rsp_timeout;
   assign o_rsp_timeout_t  = r_ctrl_t;
   assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_mul_issue_taint.sv
// Bench for mul_issue_taint: transaction-level reference model (request queue plus
// timestamped in-flight request) compared against the DUT on every cycle.
module tb_mul_issue_taint;

   localparam int W  = 4;
   localparam int D  = 4;
   localparam int TO = 12;

   // Clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic           req_valid = 0, req_valid_t = 0, req_a_t = 0, req_b_t = 0;
   logic [W-1:0]   req_a = '0, req_b = '0;
   logic           req_ready, req_ready_t;
   logic           mul_in_valid, mul_in_valid_t, mul_in_a_t, mul_in_b_t;
   logic [W-1:0]   mul_in_a, mul_in_b;
   logic           mul_out_valid = 0, mul_out_valid_t = 0, mul_out_result_t = 0;
   logic [2*W-1:0] mul_out_result = '0;
   logic           rsp_valid, rsp_valid_t, rsp_data_t, rsp_latency_t;
   logic           rsp_timeout, rsp_timeout_t;
   logic [2*W-1:0] rsp_data;
   logic [3:0]     rsp_latency;
   logic [1:0]     dbg_state;

   mul_issue_taint #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid), .i_req_valid_t(req_valid_t),
      .i_req_a(req_a), .i_req_a_t(req_a_t), .i_req_b(req_b), .i_req_b_t(req_b_t),
      .o_req_ready(req_ready), .o_req_ready_t(req_ready_t),
      .o_mul_in_valid(mul_in_valid), .o_mul_in_valid_t(mul_in_valid_t),
      .o_mul_in_a(mul_in_a), .o_mul_in_b(mul_in_b),
      .o_mul_in_a_t(mul_in_a_t), .o_mul_in_b_t(mul_in_b_t),
      .i_mul_out_valid(mul_out_valid), .i_mul_out_valid_t(mul_out_valid_t),
      .i_mul_out_result(mul_out_result), .i_mul_out_result_t(mul_out_result_t),
      .o_rsp_valid(rsp_valid), .o_rsp_valid_t(rsp_valid_t),
      .o_rsp_data(rsp_data), .o_rsp_data_t(rsp_data_t),
      .o_rsp_latency(rsp_latency), .o_rsp_latency_t(rsp_latency_t),
      .o_rsp_timeout(rsp_timeout), .o_rsp_timeout_t(rsp_timeout_t),
      .o_dbg_state(dbg_state)
   );

   // Reference model state
   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         at;
      logic         bt;
      int           vis;   // first cycle the entry is counted in the queue
   } ent_t;

   ent_t           mq[$];
   int             lat_q[$];   // planned path latencies; > TO means never answers
   ent_t           cur;
   bit             infl;
   int             iss_cyc, resp_cyc, cur_l, next_free;
   logic [2*W-1:0] m_data;
   logic [3:0]     m_lat;
   bit             m_to, m_cnt_t, m_ctrl_t, m_data_t;

   int  cyc = 0;
   int  errs = 0;
   int  checks = 0;
   int  n_acc = 0;
   bit  spur_en = 0;
   bit  force_mv = 0;
   int  tnt_pct = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      infl = 0; next_free = 0;
      m_data = '0; m_lat = '0; m_to = 0;
      m_cnt_t = 0; m_ctrl_t = 0; m_data_t = 0;
   endtask

   // One cycle: compare outputs (at negedge), drive inputs, advance the model.
   task automatic step(input bit rst_i, input bit rv, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit at, input bit bt, input bit rvt);
      bit             issue_now, resp_now, in_win, done_now, acc, mv, mvt, rt;
      bit             n_cnt_t, n_ctrl_t;
      int             e, wl;
      logic [2*W-1:0] res;
      ent_t           ne;
      issue_now = 0;
      if (!infl && mq.size() > 0) begin
         e = next_free;
         if (mq[0].vis + 1 > e) e = mq[0].vis + 1;
         issue_now = (cyc >= e);
      end
      resp_now = infl && (cyc == resp_cyc);
      wl       = (cur_l < TO) ? cur_l : TO;
      in_win   = infl && (cyc >= iss_cyc + 1) && (cyc <= iss_cyc + wl);
      done_now = in_win && (cur_l <= TO) && (cyc == iss_cyc + cur_l);

      chk("req_ready", req_ready, mq.size() < D);
      chk("req_ready_t", req_ready_t, m_cnt_t);
      chk("mul_in_valid", mul_in_valid, issue_now);
      chk("mul_in_valid_t", mul_in_valid_t, m_ctrl_t);
      if (issue_now) begin
         chk("mul_in_a", mul_in_a, mq[0].a);
         chk("mul_in_b", mul_in_b, mq[0].b);
         chk("mul_in_a_t", mul_in_a_t, mq[0].at);
         chk("mul_in_b_t", mul_in_b_t, mq[0].bt);
      end
      chk("rsp_valid", rsp_valid, resp_now);
      chk("rsp_valid_t", rsp_valid_t, m_ctrl_t);
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_data_t", rsp_data_t, m_data_t);
      chk("rsp_latency", rsp_latency, m_lat);
      chk("rsp_latency_t", rsp_latency_t, m_ctrl_t);
      chk("rsp_timeout", rsp_timeout, m_to);
      chk("rsp_timeout_t", rsp_timeout_t, m_ctrl_t);

      // Path behaviour: answers exactly at its planned latency, silent elsewhere in the wait window.
      mvt = ($urandom_range(0, 99) < tnt_pct);
      rt  = ($urandom_range(0, 99) < tnt_pct);
      if (done_now) begin
         mv  = 1;
         res = {{W{1'b0}}, cur.a} * {{W{1'b0}}, cur.b};
      end else begin
         mv  = !in_win && (force_mv || (spur_en && $urandom_range(0, 3) == 0));
         res = (2*W)'($urandom_range(0, (1 << (2*W)) - 1));
      end
      rst = rst_i;
      req_valid = rv; req_valid_t = rvt;
      req_a = a; req_a_t = at; req_b = b; req_b_t = bt;
      mul_out_valid = mv; mul_out_valid_t = mvt;
      mul_out_result = res; mul_out_result_t = rt;

      if (rst_i) begin
         model_reset();
      end else begin
         acc = rv && (mq.size() < D);
         if (infl && cyc == resp_cyc - 1) begin
            if (cur_l <= TO) begin
               m_data = res; m_lat = 4'(cur_l); m_to = 0;
            end else begin
               m_data = '0; m_lat = 4'(TO); m_to = 1;
            end
            m_data_t = m_data_t | rt | m_ctrl_t;
         end
         n_cnt_t  = m_cnt_t | rvt | m_ctrl_t;
         n_ctrl_t = m_ctrl_t | m_cnt_t | (in_win && (mvt | cur.at | cur.bt));
         m_cnt_t  = n_cnt_t;
         m_ctrl_t = n_ctrl_t;
         if (resp_now) begin
            infl = 0;
            next_free = cyc + 1;
         end
         if (issue_now) begin
            cur     = mq.pop_front();
            infl    = 1;
            iss_cyc = cyc;
            cur_l   = (lat_q.size() > 0) ? lat_q.pop_front() : int'($urandom_range(1, TO + 3));
            resp_cyc = cyc + ((cur_l < TO) ? cur_l : TO) + 1;
         end
         if (acc) begin
            ne.a = a; ne.b = b; ne.at = at; ne.bt = bt; ne.vis = cyc + 1;
            mq.push_back(ne);
            n_acc++;
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, 0);
   endtask

   task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input bit at, input bit bt);
      step(0, 1, a, b, at, bt, 0);
   endtask

   initial begin
      int guard;
      model_reset();
      cur = '{a: '0, b: '0, at: 0, bt: 0, vis: 0};
      cur_l = 1; iss_cyc = 0; resp_cyc = 0;
      repeat (3) @(negedge clk);

      // Reset values
      chk("reset_ready", req_ready, 1);
      chk("reset_mul_in_valid", mul_in_valid, 0);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_data", rsp_data, 0);
      chk("reset_rsp_latency", rsp_latency, 0);
      chk("reset_rsp_timeout", rsp_timeout, 0);
      chk("reset_state", dbg_state, 0);
      chk("reset_taints", {req_ready_t, mul_in_valid_t, rsp_valid_t, rsp_data_t,
                           rsp_latency_t, rsp_timeout_t}, 0);
      idle(2);

      // Single request answered on the 2nd wait cycle
      lat_q.push_back(2);
      push(4'd3, 4'd5, 0, 0);
      idle(4);
      chk("t1_rsp_valid", rsp_valid, 1);
      chk("t1_rsp_data", rsp_data, 15);
      chk("t1_rsp_latency", rsp_latency, 2);
      chk("t1_rsp_timeout", rsp_timeout, 0);
      idle(1);
      chk("t1_single_pulse", rsp_valid, 0);
      idle(3);

      // Stalled path: fill the queue behind a request that times out, then drain
      lat_q.push_back(TO + 8);
      lat_q.push_back(1);
      lat_q.push_back(3);
      lat_q.push_back(TO);
      lat_q.push_back(5);
      push(4'd1, 4'd2, 0, 0);
      idle(3);
      for (int i = 0; i < 4; i++) push(4'(i + 2), 4'(i + 7), 0, 0);
      chk("t2_full_ready", req_ready, 0);
      push(4'd15, 4'd15, 0, 0);
      idle(6);
      chk("t3_rsp_valid", rsp_valid, 1);
      chk("t3_timeout", rsp_timeout, 1);
      chk("t3_data", rsp_data, 0);
      chk("t3_latency", rsp_latency, 12);
      idle(1);
      chk("t3_next_issue", mul_in_valid, 1);
      chk("t3_next_a", mul_in_a, 2);
      chk("t2_pop_keeps_ready_low", req_ready, 0);
      idle(1);
      chk("t2_ready_after_pop", req_ready, 1);
      idle(60);

      // Reset during wait, stale completion afterwards
      lat_q.push_back(10);
      push(4'd9, 4'd9, 0, 0);
      idle(4);
      step(1, 0, '0, '0, 0, 0, 0);
      chk("t4_state_idle", dbg_state, 0);
      chk("t4_ready", req_ready, 1);
      force_mv = 1;
      idle(1);
      force_mv = 0;
      chk("t4_no_rsp", rsp_valid, 0);
      chk("t4_still_idle", dbg_state, 0);
      idle(15);

      // Single tainted operand
      lat_q.push_back(3);
      push(4'd4, 4'd6, 1, 0);
      idle(1);
      chk("t5_issue", mul_in_valid, 1);
      chk("t5_mul_in_a_t", mul_in_a_t, 1);
      idle(2);
      chk("t5_rsp_valid_t", rsp_valid_t, 1);
      chk("t5_rsp_latency_t", rsp_latency_t, 1);
      idle(20);
      chk("t5_sticky_valid_t", rsp_valid_t, 1);
      chk("t5_ready_t", req_ready_t, 1);
      step(1, 0, '0, '0, 0, 0, 0);
      chk("t5_cleared", {rsp_valid_t, req_ready_t, rsp_data_t}, 0);
      idle(2);

      // 50 random untainted requests with spurious completions
      spur_en = 1;
      n_acc = 0;
      guard = 0;
      while (n_acc < 50 && guard < 3000) begin
         step(0, ($urandom_range(0, 2) == 0), W'($urandom_range(0, 15)),
              W'($urandom_range(0, 15)), 0, 0, 0);
         guard++;
      end
      chk("t6_accepted_in_budget", (n_acc >= 50), 1);
      idle(100);
      chk("t6_clean_taints", {req_ready_t, mul_in_valid_t, mul_in_a_t, mul_in_b_t,
                              rsp_valid_t, rsp_data_t, rsp_latency_t, rsp_timeout_t}, 0);

      // Random taints with occasional resets
      tnt_pct = 5;
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 0),
              W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
              ($urandom_range(0, 99) < tnt_pct), ($urandom_range(0, 99) < tnt_pct),
              ($urandom_range(0, 99) < tnt_pct));
      end
      tnt_pct = 0;
      idle(80);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
